// File: rtl/hex_scroll_display.sv
// Scrolling hex message display: switch-driven write buffer shown on seven-segment digits,
// with HOLD / SCROLL_L / SCROLL_R / BLANK modes and a prescaled scroll rate.
module hex_scroll_display #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned MSG_LEN    = 8,
    parameter int unsigned TICK_DIV   = 25000000
) (
    input  logic                      CLOCK_50,
    input  logic                      RESETN,
    input  logic [9:0]                SW,
    output logic [9:0]                LED,
    output logic [7*NUM_DIGITS-1:0]   HEX
);

    localparam int unsigned PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned HW = 7 * NUM_DIGITS;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'd0,
        MODE_SCROLL_L = 2'd1,
        MODE_SCROLL_R = 2'd2,
        MODE_BLANK    = 2'd3
    } mode_e;

    // Active-low seven-segment font, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] font(input logic [3:0] code);
        case (code)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(MSG_LEN - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        ptr_dec = (p == '0) ? PW'(MSG_LEN - 1) : p - PW'(1);
    endfunction

    // Buffer entry shown on digit d; digit NUM_DIGITS-1 (leftmost) shows entry off.
    function automatic logic [PW-1:0] disp_idx(input int unsigned d, input logic [PW-1:0] off);
        int unsigned sum;
        sum      = (32'(off) + NUM_DIGITS - 1 - d) % MSG_LEN;
        disp_idx = PW'(sum);
    endfunction

    // Reset synchroniser: asserts asynchronously, releases on the clock.
    logic rst_meta_q, rst_sync_q;
    always_ff @(posedge CLOCK_50 or negedge RESETN) begin
        if (!RESETN) begin
            rst_meta_q <= 1'b0;
            rst_sync_q <= 1'b0;
        end else begin
            rst_meta_q <= 1'b1;
            rst_sync_q <= rst_meta_q;
        end
    end

    logic [9:0]               sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
    logic                     sw3_prev_q, sw3_prev_d;
    logic [CW-1:0]            presc_q, presc_d;
    logic [1:0]               step_cnt_q, step_cnt_d, rate_q, rate_d;
    logic [PW-1:0]            off_q, off_d, wr_ptr_q, wr_ptr_d;
    logic [MSG_LEN-1:0]       valid_q, valid_d;
    logic [MSG_LEN-1:0][3:0]  code_q, code_d;
    logic                     toggle_q, toggle_d;
    logic [HW-1:0]            hex_q, hex_d;
    logic [9:0]               led_q, led_d;

    mode_e mode_c;
    logic  clear_c, write_c, tick_c, rate_chg_c, step_c;

    // Next-state: synchroniser, prescaler, step counter, buffer and pointers.
    always_comb begin
        sw_meta_d  = SW;
        sw_sync_d  = sw_meta_q;
        sw3_prev_d = sw_sync_q[3];
        rate_d     = sw_sync_q[9:8];
        mode_c     = mode_e'(sw_sync_q[1:0]);
        clear_c    = sw_sync_q[2];
        write_c    = sw_sync_q[3] & ~sw3_prev_q & ~clear_c;
        tick_c     = (presc_q == CW'(TICK_DIV - 1));
        presc_d    = tick_c ? '0 : presc_q + CW'(1);
        rate_chg_c = (rate_d != rate_q);
        step_c     = tick_c & ~rate_chg_c & (step_cnt_q == rate_q);

        if (rate_chg_c || step_c) begin
            step_cnt_d = '0;
        end else if (tick_c) begin
            step_cnt_d = step_cnt_q + 2'd1;
        end else begin
            step_cnt_d = step_cnt_q;
        end

        valid_d  = valid_q;
        code_d   = code_q;
        wr_ptr_d = wr_ptr_q;
        off_d    = off_q;
        toggle_d = toggle_q;

        if (clear_c) begin
            valid_d  = '0;
            wr_ptr_d = '0;
            off_d    = '0;
        end else begin
            if (write_c) begin
                valid_d[wr_ptr_q] = 1'b1;
                code_d[wr_ptr_q]  = sw_sync_q[7:4];
                wr_ptr_d          = ptr_inc(wr_ptr_q);
            end
            if (step_c) begin
                toggle_d = ~toggle_q;
                case (mode_c)
                    MODE_SCROLL_L: off_d = ptr_inc(off_q);
                    MODE_SCROLL_R: off_d = ptr_dec(off_q);
                    default:       off_d = off_q;
                endcase
            end
        end
    end

    // Output image from the current state; registered below, so it lags by one cycle.
    always_comb begin
        hex_d = '1;
        led_d = sw_sync_q;
        if (mode_c != MODE_BLANK) begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                hex_d[7*d +: 7] = valid_q[disp_idx(d, off_q)] ? font(code_q[disp_idx(d, off_q)])
                                                              : 7'h7F;
            end
            led_d = {toggle_q, &valid_q, 4'(wr_ptr_q), 4'(off_q)};
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            sw3_prev_q <= 1'b0;
            presc_q    <= '0;
            step_cnt_q <= '0;
            rate_q     <= '0;
            off_q      <= '0;
            wr_ptr_q   <= '0;
            valid_q    <= '0;
            code_q     <= '0;
            toggle_q   <= 1'b0;
            hex_q      <= '1;
            led_q      <= '0;
        end else begin
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            sw3_prev_q <= sw3_prev_d;
            presc_q    <= presc_d;
            step_cnt_q <= step_cnt_d;
            rate_q     <= rate_d;
            off_q      <= off_d;
            wr_ptr_q   <= wr_ptr_d;
            valid_q    <= valid_d;
            code_q     <= code_d;
            toggle_q   <= toggle_d;
            hex_q      <= hex_d;
            led_q      <= led_d;
        end
    end

    assign HEX = hex_q;
    assign LED = led_q;

endmodule

// File: tb/tb_hex_scroll_display.sv
// Randomised scoreboard bench for hex_scroll_display against a cycle-level behavioural model.
module tb_hex_scroll_display;

    localparam int ND = 4;
    localparam int ML = 8;
    localparam int TD = 4;

    localparam logic [6:0] FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic [9:0]    sw = '0;
    logic [9:0]    led;
    logic [4*7-1:0] hex;

    hex_scroll_display #(
        .NUM_DIGITS(ND),
        .MSG_LEN   (ML),
        .TICK_DIV  (TD)
    ) dut (
        .CLOCK_50(clk),
        .RESETN  (rstn),
        .SW      (sw),
        .LED     (led),
        .HEX     (hex)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] hex;
        logic [9:0]  led;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    int         rel_edges;
    logic [9:0] m_pin1, m_ssw;
    logic       m_prev3;
    int         cyc, ticks_since;
    logic [1:0] last_rate;
    bit         m_valid [ML];
    logic [3:0] m_code  [ML];
    int         m_wr, m_off;
    bit         m_tog;

    function automatic exp_t expect_now();
        exp_t e;
        bit   all_v;
        int   idx;
        e.hex = '1;
        e.led = m_ssw;
        if (m_ssw[1:0] != 2'd3) begin
            all_v = 1'b1;
            for (int i = 0; i < ML; i++) all_v &= m_valid[i];
            for (int d = 0; d < ND; d++) begin
                idx = (m_off + ND - 1 - d) % ML;
                e.hex[7*d +: 7] = m_valid[idx] ? FONT[m_code[idx]] : 7'h7F;
            end
            e.led = {m_tog, all_v, 4'(m_wr), 4'(m_off)};
        end
        return e;
    endfunction

    task automatic model_reset();
        rel_edges   = 0;
        m_pin1      = '0;
        m_ssw       = '0;
        m_prev3     = 1'b0;
        cyc         = 0;
        ticks_since = 0;
        last_rate   = '0;
        m_wr        = 0;
        m_off       = 0;
        m_tog       = 1'b0;
        for (int i = 0; i < ML; i++) begin
            m_valid[i] = 1'b0;
            m_code[i]  = '0;
        end
    endtask

    // Model: each clock edge publishes the expected outputs, then advances the state.
    always @(posedge clk) begin
        exp_t rst_e;
        logic [9:0] s;
        bit wr_ev, tick, step;
        rst_e.hex = '1;
        rst_e.led = '0;
        if (!rstn) begin
            model_reset();
            exp_q.push_back(rst_e);
        end else if (rel_edges < 2) begin
            rel_edges++;
            exp_q.push_back(rst_e);
        end else begin
            exp_q.push_back(expect_now());
            s     = m_ssw;
            wr_ev = s[3] && !m_prev3 && !s[2];
            tick  = (cyc % TD) == TD - 1;
            step  = 1'b0;
            if (s[9:8] != last_rate) begin
                ticks_since = 0;
            end else if (tick) begin
                ticks_since++;
                if (ticks_since == int'(s[9:8]) + 1) begin
                    step        = 1'b1;
                    ticks_since = 0;
                end
            end
            last_rate = s[9:8];
            if (s[2]) begin
                for (int i = 0; i < ML; i++) m_valid[i] = 1'b0;
                m_wr  = 0;
                m_off = 0;
            end else begin
                if (wr_ev) begin
                    m_valid[m_wr] = 1'b1;
                    m_code[m_wr]  = s[7:4];
                    m_wr          = (m_wr + 1) % ML;
                end
                if (step) begin
                    m_tog = !m_tog;
                    if (s[1:0] == 2'd1) m_off = (m_off + 1) % ML;
                    else if (s[1:0] == 2'd2) m_off = (m_off + ML - 1) % ML;
                end
            end
            m_prev3 = s[3];
            m_ssw   = m_pin1;
            m_pin1  = sw;
            cyc++;
        end
    end

    // Monitor: the outputs are presented every cycle; compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL no_expectation t=%0t hex=%h led=%h", $time, hex, led);
        end else begin
            e = exp_q.pop_front();
            if (hex !== e.hex || led !== e.led) begin
                errors++;
                $display("FAIL outputs t=%0t hex=%h required %h led=%h required %h",
                         $time, hex, e.hex, led, e.led);
            end
        end
    end

    task automatic set_sw(input logic [9:0] v);
        @(negedge clk);
        #2 sw = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_code(input logic [3:0] code);
        logic [9:0] v;
        v      = sw;
        v[7:4] = code;
        v[3]   = 1'b1;
        set_sw(v);
        idle(3);
        v[3] = 1'b0;
        set_sw(v);
        idle(3);
    endtask

    task automatic set_mode(input logic [1:0] mode, input logic [1:0] rate);
        logic [9:0] v;
        v      = sw;
        v[1:0] = mode;
        v[9:8] = rate;
        set_sw(v);
    endtask

    task automatic clear_pulse();
        logic [9:0] v;
        v    = sw;
        v[2] = 1'b1;
        set_sw(v);
        idle(4);
        v[2] = 1'b0;
        set_sw(v);
    endtask

    task automatic reset_pulse(input int n);
        @(negedge clk);
        #2 rstn = 1'b0;
        idle(n);
        #2 rstn = 1'b1;
    endtask

    initial begin
        model_reset();
        #1 rstn = 1'b0;
        idle(3);
        #2 rstn = 1'b1;
        idle(10);

        // HOLD, write D, E, 1
        write_code(4'hD);
        write_code(4'hE);
        write_code(4'h1);
        idle(6);

        // SCROLL_L at full rate through a wrap
        set_mode(2'd1, 2'd0);
        idle(40);

        // SCROLL_R from off=0 at slowest rate
        set_mode(2'd0, 2'd0);
        clear_pulse();
        idle(4);
        for (int i = 0; i < 3; i++) write_code(4'(i + 3));
        set_mode(2'd2, 2'd3);
        idle(80);

        // Fill and overwrite the buffer in HOLD
        set_mode(2'd0, 2'd0);
        for (int i = 0; i < 9; i++) write_code(4'(15 - i));
        idle(6);

        // BLANK mirrors switches, then clear and return to HOLD
        set_sw(10'h3A3);
        idle(8);
        set_sw(10'h3A7);
        idle(6);
        set_sw(10'h000);
        idle(6);

        // Reset in the middle of scrolling and writing
        set_mode(2'd1, 2'd1);
        write_code(4'h7);
        write_code(4'h8);
        begin
            logic [9:0] v;
            v      = sw;
            v[7:4] = 4'hA;
            v[3]   = 1'b1;
            set_sw(v);
            reset_pulse(3);
            idle(6);
            v[3] = 1'b0;
            set_sw(v);
        end
        idle(10);
        write_code(4'hC);
        idle(20);

        // Randomised phase
        for (int it = 0; it < 250; it++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 40) begin
                write_code(4'($urandom_range(0, 15)));
            end else if (r < 70) begin
                set_mode(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end else if (r < 76) begin
                clear_pulse();
            end else if (r < 79) begin
                reset_pulse(int'($urandom_range(1, 4)));
            end
            idle(int'($urandom_range(1, 20)));
        end

        idle(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
